aes_mix_col_seq: RTL and testbench
==================================

# aes_mix_col_seq

Column sequencer for the 32-bit MixColumns/InvMixColumns datapath. It accepts a full 128-bit AES state with round and direction information, then feeds the four columns through the shared single-column datapath on consecutive cycles. It reassembles the 128-bit result and returns it under a valid/ready handshake. It sits between the round controller and the column datapath, so the round controller never handles 32-bit slices.

## Interface
Parameters:
- ROUND_W, 4, width of round-count fields.

Ports (clock and reset first):
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- SEQ_START  in  1  input valid; a block is accepted when SEQ_START & SEQ_READY.
- SEQ_READY  out  1  sequencer can accept a block.
- SEQ_STATE_IN  in  128  AES state; column 0 = [127:96], column 3 = [31:0].
- SEQ_E_D  in  1  1 = encrypt (MixColumns), 0 = decrypt (InvMixColumns).
- SEQ_COUNT_ROUND  in  ROUND_W  current round number.
- SEQ_FINAL_ROUND_COUNT  in  ROUND_W  final round number.
- SEQ_VALID_OUT  out  1  SEQ_STATE_OUT holds a completed block.
- SEQ_READY_IN  in  1  downstream accepts SEQ_STATE_OUT.
- SEQ_STATE_OUT  out  128  result, same column ordering as input.
- MC_IN  out  32  column to datapath.
- MC_E_D  out  1  latched direction to datapath.
- MC_COUNT_ROUND  out  ROUND_W  latched round to datapath.
- MC_FINAL_ROUND_COUNT  out  ROUND_W  latched final round to datapath.
- MC_I_MIX_ACTIVE  out  1  datapath input enable.
- MC_OUT  in  32  combinational datapath result for MC_IN.

## Operation
- States are IDLE, BUSY and DONE. A 2-bit column counter COL is used only in BUSY.
- **IDLE**
  - SEQ_READY = 1.
  - On accept, latch SEQ_STATE_IN, SEQ_E_D and both round fields into internal registers.
  - Set COL = 0 and go to BUSY.
- **BUSY**
  - MC_IN = latched column COL.
  - MC_I_MIX_ACTIVE = 1.
  - MC_E_D and the two round outputs are driven from the latches.
  - Each edge writes MC_OUT into output slot COL and increments COL.
  - The edge with COL = 3 moves the state to DONE.
  - SEQ_READY = 0. SEQ_START is ignored.
- **DONE**
  - SEQ_VALID_OUT = 1. SEQ_STATE_OUT is stable.
  - SEQ_READY = SEQ_READY_IN, so a new block can be accepted in the same cycle the result is consumed.
  - If SEQ_READY_IN & SEQ_START: latch the new block and go to BUSY with COL = 0.
  - If SEQ_READY_IN only: go to IDLE.
  - Otherwise: hold in DONE.
- Outside BUSY, MC_IN = 0 and MC_I_MIX_ACTIVE = 0. Outputs are never driven to z.
- Final-round bypass is performed by the datapath when MC_COUNT_ROUND == MC_FINAL_ROUND_COUNT. The sequencer still runs four column cycles, so latency is uniform.
- Input latches change only on accept. Changes on SEQ_* inputs at other times have no effect on a block in flight.

## Timing
- Reset values (asynchronous, RST_N low):
  - state = IDLE, COL = 0.
  - All latches and SEQ_STATE_OUT = 0.
  - SEQ_VALID_OUT = 0, SEQ_READY = 1 (once state is IDLE).
  - MC_IN = 0, MC_I_MIX_ACTIVE = 0, MC_E_D = 0, round outputs = 0.
- Latency: accept at edge E0, columns captured at E1 to E4, SEQ_VALID_OUT high from E4. The result is 4 cycles after accept.
- Throughput: back-to-back blocks with SEQ_READY_IN held high complete every 5 cycles (4 BUSY + 1 DONE).
- Reset asserted mid-BUSY or in DONE: the block is discarded, and no partial result is ever flagged valid.
- SEQ_READY_IN = 0 in DONE: output and latches hold indefinitely.

## Structure
- Shared package aes_pkg holds:
  - seq_state_t enum (IDLE, BUSY, DONE).
  - AES_COL_W = 32, AES_STATE_W = 128, AES_NUM_COLS = 4.
- The MixColumns datapath is external; this block only connects to it.
- One natural sub-module: aes_col_sel, a 128→32 column mux indexed by COL. The demux write into output slot COL stays in the top level.

## Test plan
All scenarios run with the real column datapath attached.

- **Encrypt:** SEQ_STATE_IN = db135345_f20a225c_01010101_c6c6c6c6, E_D = 1, round 1 / final 10 → SEQ_STATE_OUT = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, SEQ_VALID_OUT high exactly 4 cycles after accept.
- **Decrypt:** SEQ_STATE_IN = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, E_D = 0, round 1 / final 10 → db135345_f20a225c_01010101_c6c6c6c6.
- **Final round:** same input as the encrypt case, round 10 / final 10 → output equals input unchanged; MC_I_MIX_ACTIVE high for exactly 4 cycles.
- **Back-pressure and back-to-back:**
  - Hold SEQ_READY_IN = 0 for 6 cycles in DONE → output stable, SEQ_READY = 0, SEQ_START ignored.
  - Raise SEQ_READY_IN together with SEQ_START → the second block is accepted in that cycle, and its result appears 4 cycles later.
- **Input changes during BUSY:** toggle SEQ_STATE_IN and SEQ_E_D every cycle while BUSY → result matches the values latched at accept.
- **Reset mid-operation:** assert RST_N = 0 at COL = 2 → all outputs take their reset values immediately; after release, SEQ_VALID_OUT stays 0 and SEQ_READY = 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES sequencer types and widths.
// Imported by the column sequencer, its interface and its column mux.
package aes_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam int AES_COL_W    = 32;
   localparam int AES_STATE_W  = 128;
   localparam int AES_NUM_COLS = 4;
endpackage

// File: rtl/aes_mix_col_seq_if.sv
// Round-controller and column-datapath bus of the MixColumns column sequencer.
// slave = sequencer side, master = round controller plus datapath side.
interface aes_mix_col_seq_if
   import aes_pkg::*;
#(
   parameter int ROUND_W = 4
);
   logic                   SEQ_START;
   logic                   SEQ_READY;
   logic [AES_STATE_W-1:0] SEQ_STATE_IN;
   logic                   SEQ_E_D;
   logic [ROUND_W-1:0]     SEQ_COUNT_ROUND;
   logic [ROUND_W-1:0]     SEQ_FINAL_ROUND_COUNT;
   logic                   SEQ_VALID_OUT;
   logic                   SEQ_READY_IN;
   logic [AES_STATE_W-1:0] SEQ_STATE_OUT;
   logic [AES_COL_W-1:0]   MC_IN;
   logic                   MC_E_D;
   logic [ROUND_W-1:0]     MC_COUNT_ROUND;
   logic [ROUND_W-1:0]     MC_FINAL_ROUND_COUNT;
   logic                   MC_I_MIX_ACTIVE;
   logic [AES_COL_W-1:0]   MC_OUT;

   modport slave (
      input  SEQ_START, SEQ_STATE_IN, SEQ_E_D, SEQ_COUNT_ROUND,
             SEQ_FINAL_ROUND_COUNT, SEQ_READY_IN, MC_OUT,
      output SEQ_READY, SEQ_VALID_OUT, SEQ_STATE_OUT, MC_IN, MC_E_D,
             MC_COUNT_ROUND, MC_FINAL_ROUND_COUNT, MC_I_MIX_ACTIVE
   );

   modport master (
      output SEQ_START, SEQ_STATE_IN, SEQ_E_D, SEQ_COUNT_ROUND,
             SEQ_FINAL_ROUND_COUNT, SEQ_READY_IN, MC_OUT,
      input  SEQ_READY, SEQ_VALID_OUT, SEQ_STATE_OUT, MC_IN, MC_E_D,
             MC_COUNT_ROUND, MC_FINAL_ROUND_COUNT, MC_I_MIX_ACTIVE
   );
endinterface

// File: rtl/aes_col_sel.sv
// 128-to-32 column mux; column 0 is the most significant word.
// Combinational, no backpressure.
module aes_col_sel
   import aes_pkg::*;
(
   input  logic [AES_STATE_W-1:0] i_blk,
   input  logic [1:0]             i_col,
   output logic [AES_COL_W-1:0]   o_col
);
   always_comb begin
      o_col = '0;
      for (int c = 0; c < AES_NUM_COLS; c++) begin
         if (i_col == c[1:0]) begin
            o_col = i_blk[(AES_NUM_COLS-1-c)*AES_COL_W +: AES_COL_W];
         end
      end
   end
endmodule

// File: rtl/aes_mix_col_seq.sv
// Feeds a latched 128-bit state through the shared column datapath, one column per cycle.
// Result valid 4 cycles after accept; a result held in DONE stalls new accepts until taken.
module aes_mix_col_seq
   import aes_pkg::*;
#(
   parameter int ROUND_W = 4
)(
   input  logic              CLK,
   input  logic              RST_N,
   aes_mix_col_seq_if.slave  seq
);
   seq_state_t             r_state;
   logic [1:0]             r_col;
   logic [AES_STATE_W-1:0] r_blk;
   logic [AES_STATE_W-1:0] r_res;
   logic                   r_e_d;
   logic [ROUND_W-1:0]     r_round;
   logic [ROUND_W-1:0]     r_final;
   logic [AES_COL_W-1:0]   w_col;
   logic                   w_busy;
   logic                   w_accept;

   aes_col_sel u_col_sel (
      .i_blk (r_blk),
      .i_col (r_col),
      .o_col (w_col)
   );

   assign w_busy   = (r_state == BUSY);
   // DONE forwards downstream ready so a result can be swapped for a new block in one cycle
   assign seq.SEQ_READY = (r_state == IDLE) | ((r_state == DONE) & seq.SEQ_READY_IN);
   assign w_accept = seq.SEQ_START & seq.SEQ_READY;

   assign seq.SEQ_VALID_OUT        = (r_state == DONE);
   assign seq.SEQ_STATE_OUT        = r_res;
   assign seq.MC_IN                = w_busy ? w_col : '0;
   assign seq.MC_I_MIX_ACTIVE      = w_busy;
   assign seq.MC_E_D               = r_e_d;
   assign seq.MC_COUNT_ROUND       = r_round;
   assign seq.MC_FINAL_ROUND_COUNT = r_final;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_col   <= '0;
         r_blk   <= '0;
         r_res   <= '0;
         r_e_d   <= 1'b0;
         r_round <= '0;
         r_final <= '0;
      end else begin
         if (w_accept) begin
            r_blk   <= seq.SEQ_STATE_IN;
            r_e_d   <= seq.SEQ_E_D;
            r_round <= seq.SEQ_COUNT_ROUND;
            r_final <= seq.SEQ_FINAL_ROUND_COUNT;
            r_col   <= '0;
            r_state <= BUSY;
         end
         case (r_state)
            BUSY: begin
               for (int c = 0; c < AES_NUM_COLS; c++) begin
                  if (r_col == c[1:0]) begin
                     r_res[(AES_NUM_COLS-1-c)*AES_COL_W +: AES_COL_W] <= seq.MC_OUT;
                  end
               end
               r_col <= r_col + 2'd1;
               if (r_col == 2'd3) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (seq.SEQ_READY_IN && !seq.SEQ_START) begin
                  r_state <= IDLE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_mix_col_seq.sv
// Bench for the column sequencer with a behavioural MixColumns datapath attached.
// Expected blocks are queued on accept and compared by a monitor when the result is taken.
module tb_aes_mix_col_seq;
   localparam logic [127:0] PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] MIXED = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

   logic CLK;
   logic RST_N;
   int   n_chk;
   int   n_err;
   logic [127:0] exp_q[$];

   aes_mix_col_seq_if #(.ROUND_W(4)) bus ();

   aes_mix_col_seq #(.ROUND_W(4)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .seq   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] dp(input logic [31:0] c, input logic ed,
                                      input logic [3:0] rnd, input logic [3:0] fin);
      logic [7:0] a [4];
      logic [7:0] m [4];
      logic [31:0] r;
      if (rnd == fin) return c;
      for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
      if (ed) begin
         m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      end else begin
         m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      end
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[31-8*i -: 8] = gmul(a[i], m[0]) ^ gmul(a[(i+1)%4], m[1])
                        ^ gmul(a[(i+2)%4], m[2]) ^ gmul(a[(i+3)%4], m[3]);
      end
      return r;
   endfunction

   assign bus.MC_OUT = dp(bus.MC_IN, bus.MC_E_D, bus.MC_COUNT_ROUND, bus.MC_FINAL_ROUND_COUNT);

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Scoreboard monitor: compares every block the downstream takes
   always @(negedge CLK) begin
      if (RST_N && bus.SEQ_VALID_OUT && bus.SEQ_READY_IN) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", bus.SEQ_STATE_OUT, 128'hx);
         end else begin
            chk("result", bus.SEQ_STATE_OUT, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [127:0] blk, input logic ed, input logic [3:0] rnd,
                       input logic [3:0] fin, input logic [127:0] expv);
      bit ok;
      ok = 1'b0;
      bus.SEQ_START             = 1'b1;
      bus.SEQ_STATE_IN          = blk;
      bus.SEQ_E_D               = ed;
      bus.SEQ_COUNT_ROUND       = rnd;
      bus.SEQ_FINAL_ROUND_COUNT = fin;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge CLK);
         if (bus.SEQ_READY) begin
            ok = 1'b1;
            exp_q.push_back(expv);
         end
         @(posedge CLK);
         #1;
      end
      bus.SEQ_START = 1'b0;
      if (!ok) chk("accept_timeout", 128'd0, 128'd1);
   endtask

   // Called at accept edge + 1; walks E1..E4 checking the column schedule and latency
   task automatic run(input logic [127:0] blk, input bit toggle);
      chk("mc_in_col0", {96'd0, bus.MC_IN}, {96'd0, blk[127:96]});
      chk("mix_active_e0", {127'd0, bus.MC_I_MIX_ACTIVE}, 128'd1);
      for (int i = 1; i <= 4; i++) begin
         if (toggle) begin
            bus.SEQ_STATE_IN = ~bus.SEQ_STATE_IN;
            bus.SEQ_E_D      = ~bus.SEQ_E_D;
         end
         @(posedge CLK);
         #1;
         chk("valid_latency", {127'd0, bus.SEQ_VALID_OUT}, {127'd0, (i == 4)});
         chk("mix_active", {127'd0, bus.MC_I_MIX_ACTIVE}, {127'd0, (i < 4)});
         if (i < 4) chk("ready_busy", {127'd0, bus.SEQ_READY}, 128'd0);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_valid", {127'd0, bus.SEQ_VALID_OUT}, 128'd0);
      chk("rst_ready", {127'd0, bus.SEQ_READY}, 128'd1);
      chk("rst_state_out", bus.SEQ_STATE_OUT, 128'd0);
      chk("rst_mc_in", {96'd0, bus.MC_IN}, 128'd0);
      chk("rst_mix_active", {127'd0, bus.MC_I_MIX_ACTIVE}, 128'd0);
      chk("rst_mc_misc", {119'd0, bus.MC_E_D, bus.MC_COUNT_ROUND, bus.MC_FINAL_ROUND_COUNT}, 128'd0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      bus.SEQ_START             = 1'b0;
      bus.SEQ_STATE_IN          = '0;
      bus.SEQ_E_D               = 1'b0;
      bus.SEQ_COUNT_ROUND       = '0;
      bus.SEQ_FINAL_ROUND_COUNT = '0;
      bus.SEQ_READY_IN          = 1'b1;
      RST_N = 1'b1;
      #1 RST_N = 1'b0;
      #2 chk_reset_vals();
      #20 RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // Encrypt, decrypt, final-round bypass; each send lands back-to-back on DONE
      send(PLAIN, 1'b1, 4'd1, 4'd10, MIXED);
      run(PLAIN, 1'b0);
      send(MIXED, 1'b0, 4'd1, 4'd10, PLAIN);
      run(MIXED, 1'b0);
      send(PLAIN, 1'b1, 4'd10, 4'd10, PLAIN);
      run(PLAIN, 1'b0);

      // Input changes while busy must not disturb the latched block
      send(PLAIN, 1'b1, 4'd1, 4'd10, MIXED);
      run(PLAIN, 1'b1);

      // Back-pressure: result held, new starts refused, then swapped in one cycle
      @(posedge CLK);
      #1;
      bus.SEQ_READY_IN = 1'b0;
      send(PLAIN, 1'b1, 4'd3, 4'd10, MIXED);
      run(PLAIN, 1'b0);
      bus.SEQ_START    = 1'b1;
      bus.SEQ_STATE_IN = {4{32'hffff_ffff}};
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("hold_ready", {127'd0, bus.SEQ_READY}, 128'd0);
         chk("hold_valid", {127'd0, bus.SEQ_VALID_OUT}, 128'd1);
         chk("hold_out", bus.SEQ_STATE_OUT, MIXED);
         @(posedge CLK);
         #1;
      end
      bus.SEQ_READY_IN = 1'b1;
      send(MIXED, 1'b0, 4'd2, 4'd10, PLAIN);
      run(MIXED, 1'b0);

      // Reset while COL = 2
      send(PLAIN, 1'b1, 4'd1, 4'd10, MIXED);
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      RST_N = 1'b0;
      #1 chk_reset_vals();
      exp_q.delete();
      #2 RST_N = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("post_rst_valid", {127'd0, bus.SEQ_VALID_OUT}, 128'd0);
         chk("post_rst_ready", {127'd0, bus.SEQ_READY}, 128'd1);
      end

      for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge CLK);
      if (exp_q.size() != 0) chk("drain_timeout", 128'd0, 128'd1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
